dcache_direct_mapped: RTL
=========================

// Module: dcache_direct_mapped
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data cache between the MEM-stage load/store
//  request and the byte-addressed data memory. Load hits return in the request cycle. Load misses
//  stall the pipeline while the line is refilled one word per cycle using the memory's LW mode.
//  Stores go straight through to memory with zero stall and update the cached copy on a hit.
//  Access-mode encoding matches the data memory (3-bit code):
//  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
// PARAMETERS
//  ADDRESS_WIDTH   32  byte address width
//  DATA_WIDTH      32  word width
//  SETS            64  number of lines (power of 2); index = addr[4 +: log2(SETS)]
//  WORDS_PER_LINE   4  words per line (fixed 4); offset = addr[3:0]; tag = remaining upper bits
// PORTS
//  clk        in   1              clock, all state on posedge
//  rst_n      in   1              asynchronous active-low reset
//  cpu_req    in   1              access valid this cycle
//  cpu_mode   in   3              access mode (encoding above)
//  cpu_addr   in   ADDRESS_WIDTH  byte address
//  cpu_wdata  in   DATA_WIDTH     store data, low bytes used for SB/SH
//  cpu_rdata  out  DATA_WIDTH     load result, sign/zero-extended; valid when cpu_req & load & !stall
//  stall      out  1              hold pipeline; cpu_* must stay stable while high
//  flush_req  in   1              pulse: invalidate the whole cache
//  mem_addr   out  ADDRESS_WIDTH  to data memory address
//  mem_wdata  out  DATA_WIDTH     to data memory data_in
//  mem_mode   out  3              to data memory write_en; 3'b010 (harmless read) when idle
//  mem_rdata  in   DATA_WIDTH     from data memory data_out (combinational)
// BEHAVIOUR
//  Reset (async): all valid bits 0, state IDLE, refill/flush counter 0, no pending flush.
//   Outputs while reset is held: stall=0, cpu_rdata=0, mem_mode=010, mem_addr=0, mem_wdata=0.
//  FSM states: IDLE, REFILL, FLUSH.
//  IDLE, load, aligned (LH/LHU addr[0]=0, LW addr[1:0]=0):
//   - hit: cpu_rdata extracted from the line combinationally, stall=0.
//   - miss: stall=1, go to REFILL with cnt=0.
//  REFILL: mem_mode=010, mem_addr={tag,index,cnt[1:0],2'b00}; the word is captured at each posedge.
//   On cnt=3: write tag, set valid, go to IDLE. The re-lookup then hits.
//   stall is high for exactly WORDS_PER_LINE+1 cycles per miss.
//  IDLE, misaligned load: bypass with mem_mode=cpu_mode, mem_addr=cpu_addr,
//   cpu_rdata=mem_rdata, stall=0, cache untouched.
//  IDLE, store (101/110/111): in the same cycle mem_mode=cpu_mode, mem_addr=cpu_addr,
//   mem_wdata=cpu_wdata; memory writes on that posedge; stall=0.
//   - aligned and hit: the affected bytes of the cached word are updated on the same edge.
//   - aligned and miss: no allocation.
//   - misaligned (SH addr[0]=1 or SW addr[1:0]!=0): clear valid of set index(addr) and
//     index(addr+3), whether or not they hit.
//  Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
//   Byte lane = addr[1:0]; half lane = addr[1].
//  cpu_req=0 or an undefined mode: no state change, mem_mode=010, cpu_rdata=0.
//  flush_req: latched as pending if it arrives during REFILL (the refill completes first).
//   FLUSH clears one valid bit per cycle (set 0..SETS-1), with stall=1 for SETS cycles, then IDLE.
//   flush_req in IDLE takes priority over a same-cycle cpu_req, which is replayed afterwards.
//   flush_req during FLUSH is ignored.
//  Reset mid-REFILL/FLUSH: immediate abort; the partially refilled line is never marked valid.
// TESTING
//  1 Reset; LW 0x10000 (mem word 0x11223344) -> stall 5 cycles;
//    mem_addr 0x10000,0x10004,0x10008,0x1000C; cpu_rdata 0x11223344; repeat LW -> stall 0.
//  2 Line cached, byte 0x10003=0x80: LB -> 0xFFFFFF80; LBU -> 0x00000080; LH 0x10002 -> 0xFFFF80xx.
//  3 SW 0x10004=0xDEADBEEF on a hit -> mem_mode 111 that cycle, stall 0;
//    next LW 0x10004 hits, returns 0xDEADBEEF.
//  4 Conflict: LW 0x10000 then LW 0x10400 (same set 0) -> both miss;
//    LW 0x10000 again -> misses (evicted).
//  5 Misaligned LW 0x10001 -> stall 0, mem_mode 010, mem_addr 0x10001, cpu_rdata=mem_rdata;
//    SW 0x1000E -> sets 0 and 1 invalid.
//  6 flush_req mid-refill -> refill ends, then stall 64 cycles, then a prior hit misses;
//    rst_n low mid-refill -> stall 0 at once, line invalid.

Source files
------------

// File: rtl/dcache_direct_mapped_if.sv
// Bus bundle between the MEM stage, the direct-mapped data cache and the data memory.
// The master side is the pipeline plus memory; the slave side is the cache itself.
interface dcache_direct_mapped_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     cpu_req;
  logic [2:0]               cpu_mode;
  logic [ADDRESS_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0]    cpu_wdata;
  logic [DATA_WIDTH-1:0]    cpu_rdata;
  logic                     stall;
  logic                     flush_req;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [2:0]               mem_mode;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport master (
    output cpu_req, cpu_mode, cpu_addr, cpu_wdata, flush_req, mem_rdata,
    input  cpu_rdata, stall, mem_addr, mem_wdata, mem_mode
  );

  modport slave (
    input  cpu_req, cpu_mode, cpu_addr, cpu_wdata, flush_req, mem_rdata,
    output cpu_rdata, stall, mem_addr, mem_wdata, mem_mode
  );
endinterface

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Load hits answer combinationally; misses refill one word per cycle through the memory's LW port.
module dcache_direct_mapped #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  dcache_direct_mapped_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDRESS_WIDTH - 4 - IDX_W;
  localparam int CNT_W = (IDX_W > 2) ? IDX_W : 2;

  localparam logic [2:0] MODE_LB  = 3'b000;
  localparam logic [2:0] MODE_LH  = 3'b001;
  localparam logic [2:0] MODE_LW  = 3'b010;
  localparam logic [2:0] MODE_LBU = 3'b011;
  localparam logic [2:0] MODE_LHU = 3'b100;
  localparam logic [2:0] MODE_SB  = 3'b101;
  localparam logic [2:0] MODE_SH  = 3'b110;
  localparam logic [2:0] MODE_SW  = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_REFILL, ST_FLUSH} state_t;

  state_t             st_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               flush_pend_q;
  logic [SETS-1:0]    valid_q;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS*WORDS_PER_LINE];

  logic [IDX_W-1:0]      idx, idx_hi;
  logic [TAG_W-1:0]      tag;
  logic                  is_store, aligned, hit, refill_last, store_hit_we;
  logic [DATA_WIDTH-1:0] word;

  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] mode,
                                                        input logic [DATA_WIDTH-1:0] w,
                                                        input logic [1:0] lane);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[8*lane +: 8];
    h = w[16*lane[1] +: 16];
    case (mode)
      MODE_LB:  return {{(DATA_WIDTH-8){b[7]}}, b};
      MODE_LH:  return {{(DATA_WIDTH-16){h[15]}}, h};
      MODE_LBU: return {{(DATA_WIDTH-8){1'b0}}, b};
      MODE_LHU: return {{(DATA_WIDTH-16){1'b0}}, h};
      default:  return w;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [2:0] mode,
                                                        input logic [DATA_WIDTH-1:0] old,
                                                        input logic [DATA_WIDTH-1:0] wd,
                                                        input logic [1:0] lane);
    logic [DATA_WIDTH-1:0] r;
    r = old;
    case (mode)
      MODE_SB: r[8*lane +: 8]       = wd[7:0];
      MODE_SH: r[16*lane[1] +: 16]  = wd[15:0];
      default: r                    = wd;
    endcase
    return r;
  endfunction

  assign idx      = bus.cpu_addr[4 +: IDX_W];
  assign tag      = bus.cpu_addr[ADDRESS_WIDTH-1 -: TAG_W];
  // A 4-byte access starting at offset 13..15 spills into the next set.
  assign idx_hi   = idx + IDX_W'(bus.cpu_addr[3:0] >= 4'd13);
  assign is_store = (bus.cpu_mode == MODE_SB) || (bus.cpu_mode == MODE_SH) ||
                    (bus.cpu_mode == MODE_SW);
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign word     = data_q[{idx, bus.cpu_addr[3:2]}];
  assign refill_last  = (cnt_q[1:0] == 2'(WORDS_PER_LINE-1));
  assign store_hit_we = (st_q == ST_IDLE) && !bus.flush_req && bus.cpu_req &&
                        is_store && aligned && hit;

  always_comb begin
    aligned = 1'b1;
    case (bus.cpu_mode)
      MODE_LH, MODE_LHU, MODE_SH: aligned = ~bus.cpu_addr[0];
      MODE_LW, MODE_SW:           aligned = (bus.cpu_addr[1:0] == 2'b00);
      default:                    aligned = 1'b1;
    endcase
  end

  always_comb begin
    bus.stall     = 1'b0;
    bus.cpu_rdata = '0;
    bus.mem_mode  = MODE_LW;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (rst_n) begin
      case (st_q)
        ST_IDLE: begin
          // A same-cycle access is held off until the flush has run.
          if (bus.flush_req) begin
            bus.stall = bus.cpu_req;
          end else if (bus.cpu_req) begin
            if (is_store) begin
              bus.mem_mode  = bus.cpu_mode;
              bus.mem_addr  = bus.cpu_addr;
              bus.mem_wdata = bus.cpu_wdata;
            end else if (!aligned) begin
              bus.mem_mode  = bus.cpu_mode;
              bus.mem_addr  = bus.cpu_addr;
              bus.cpu_rdata = bus.mem_rdata;
            end else if (hit) begin
              bus.cpu_rdata = load_extend(bus.cpu_mode, word, bus.cpu_addr[1:0]);
            end else begin
              bus.stall = 1'b1;
            end
          end
        end
        ST_REFILL: begin
          bus.stall    = 1'b1;
          bus.mem_addr = {tag, idx, cnt_q[1:0], 2'b00};
        end
        ST_FLUSH: bus.stall = 1'b1;
        default:  bus.stall = 1'b0;
      endcase
    end
  end

  // Control state: FSM, shared refill/flush counter, valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= ST_IDLE;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (bus.flush_req) begin
            st_q  <= ST_FLUSH;
            cnt_q <= '0;
          end else if (bus.cpu_req) begin
            if (is_store && !aligned) begin
              valid_q[idx]    <= 1'b0;
              valid_q[idx_hi] <= 1'b0;
            end else if (!is_store && aligned && !hit) begin
              st_q  <= ST_REFILL;
              cnt_q <= '0;
            end
          end
        end
        ST_REFILL: begin
          if (bus.flush_req) flush_pend_q <= 1'b1;
          if (refill_last) begin
            valid_q[idx] <= 1'b1;
            cnt_q        <= '0;
            st_q         <= (flush_pend_q || bus.flush_req) ? ST_FLUSH : ST_IDLE;
            flush_pend_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_FLUSH: begin
          valid_q[cnt_q[IDX_W-1:0]] <= 1'b0;
          if (cnt_q == CNT_W'(SETS-1)) begin
            st_q  <= ST_IDLE;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  // Line storage: refill words, tag on the last refill beat, store-hit merges
  always_ff @(posedge clk) begin
    if (st_q == ST_REFILL) begin
      data_q[{idx, cnt_q[1:0]}] <= bus.mem_rdata;
      if (refill_last) tag_q[idx] <= tag;
    end
    if (store_hit_we)
      data_q[{idx, bus.cpu_addr[3:2]}] <= store_merge(bus.cpu_mode, word, bus.cpu_wdata,
                                                      bus.cpu_addr[1:0]);
  end
endmodule
